// File: rtl/mux_scan_sequencer_pkg.sv
// rtl/mux_scan_sequencer_pkg.sv - shared constants and FSM encoding for the mux scan sequencer
// Contents: channel count, select width, default dwell width, scan FSM state type.
package mux_scan_sequencer_pkg;

  localparam int NUM_CH          = 4;
  localparam int SEL_W           = 2;
  localparam int DEFAULT_DWELL_W = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } scan_state_t;

endpackage

// File: rtl/dwell_counter.sv
// rtl/dwell_counter.sv - per-channel dwell counter with synchronous load and terminal count
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   load      : clear count to 0 (takes priority over en)
//   en        : count one cycle; wraps to 0 after reaching term
//   term      : terminal value (dwell cycles minus 1)
//   tc        : high while count equals term
module dwell_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic         tc
);

  logic [W-1:0] cnt;

  // Clearing on terminal count means term = all-ones never relies on overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (en) begin
      if (cnt == term) cnt <= '0;
      else             cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == term);

endmodule

// File: rtl/mux_scan_sequencer.sv
// rtl/mux_scan_sequencer.sv - steps a 4:1 mux through its channels and snapshots each full scan
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   en              : block enable; low aborts a scan
//   start           : one-cycle scan request, honoured only when idle
//   cont            : continuous (1) / single-shot (0), latched at start
//   dwell           : cycles per channel minus 1, latched at start
//   mux_out         : data returned by the downstream mux
//   select          : channel select to the mux
//   busy            : high whenever not idle
//   sample          : last complete snapshot, bit n = channel n
//   sample_valid    : one-cycle pulse when sample updates
//   sample_changed  : with sample_valid, new sample differs from previous
module mux_scan_sequencer
  import mux_scan_sequencer_pkg::*;
#(
  parameter int DWELL_W = DEFAULT_DWELL_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               start,
  input  logic               cont,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               mux_out,
  output logic [SEL_W-1:0]   select,
  output logic               busy,
  output logic [NUM_CH-1:0]  sample,
  output logic               sample_valid,
  output logic               sample_changed
);

  scan_state_t               state, state_next;
  logic [DWELL_W-1:0]        dwell_q;
  logic                      cont_q;
  logic [NUM_CH-2:0]         shadow;
  logic                      cnt_load;
  logic                      cnt_en;
  logic                      cnt_tc;
  logic                      capture;
  logic                      last_ch;
  logic [NUM_CH-1:0]         new_sample;

  assign last_ch    = (select == SEL_W'(NUM_CH - 1));
  assign new_sample = {mux_out, shadow};

  dwell_counter #(.W(DWELL_W)) u_dwell_counter (
    .clk  (clk),
    .rst  (rst),
    .load (cnt_load),
    .en   (cnt_en),
    .term (dwell_q),
    .tc   (cnt_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    cnt_load   = 1'b0;
    cnt_en     = 1'b0;
    capture    = 1'b0;
    case (state)
      ST_IDLE: begin
        // Counter held at zero so the first SCAN cycle starts a fresh dwell.
        cnt_load = 1'b1;
        if (start && en) state_next = ST_SCAN;
      end
      ST_SCAN: begin
        if (!en) begin
          cnt_load   = 1'b1;
          state_next = ST_IDLE;
        end else begin
          cnt_en  = 1'b1;
          capture = cnt_tc;
          if (cnt_tc && last_ch && !cont_q) state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      select         <= '0;
      busy           <= 1'b0;
      dwell_q        <= '0;
      cont_q         <= 1'b0;
      shadow         <= '0;
      sample         <= '0;
      sample_valid   <= 1'b0;
      sample_changed <= 1'b0;
    end else begin
      sample_valid   <= 1'b0;
      sample_changed <= 1'b0;
      busy           <= (state_next != ST_IDLE);
      case (state)
        ST_IDLE: begin
          select <= '0;
          if (start && en) begin
            dwell_q <= dwell;
            cont_q  <= cont;
          end
        end
        ST_SCAN: begin
          if (!en) begin
            // Abort: partial scan is thrown away, sample keeps its last value.
            select <= '0;
            shadow <= '0;
          end else if (capture) begin
            select <= select + 1'b1;
            if (last_ch) begin
              sample         <= new_sample;
              sample_valid   <= 1'b1;
              sample_changed <= (new_sample != sample);
            end else begin
              shadow[select] <= mux_out;
            end
          end
        end
        default: select <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// tb/tb_mux_scan_sequencer.sv - self-checking bench for mux_scan_sequencer
module tb_mux_scan_sequencer;

  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          start = 1'b0;
  logic          cont = 1'b0;
  logic [DW-1:0] dwell = '0;
  logic          mux_out;
  logic [1:0]    select;
  logic          busy;
  logic [3:0]    sample;
  logic          sample_valid;
  logic          sample_changed;

  logic [3:0]    chan_val = 4'h0;   // value each mux channel presents
  logic [3:0]    model_prev = 4'h0; // reference model: last reported sample
  int            errors = 0;
  int            checks = 0;

  always #5 clk = ~clk;

  assign mux_out = chan_val[select];

  mux_scan_sequencer #(.DWELL_W(DW)) dut (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .start          (start),
    .cont           (cont),
    .dwell          (dwell),
    .mux_out        (mux_out),
    .select         (select),
    .busy           (busy),
    .sample         (sample),
    .sample_valid   (sample_valid),
    .sample_changed (sample_changed)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Start a scan and check every cycle against the scan rules.
  // pat < 0 picks random channel values per scan; disturb re-pulses start and
  // changes dwell/cont while busy, which must have no effect.
  task automatic run_scan(input int d, input bit c, input int ncyc, input int pat, input bit disturb);
    int         p;
    bit         exp_busy, exp_valid;
    int         exp_sel;
    logic [3:0] scan_val;
    p        = 4 * (d + 1);
    dwell    = DW'(d);
    cont     = c;
    chan_val = (pat < 0) ? 4'($urandom) : 4'(pat);
    scan_val = chan_val;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 1; n <= ncyc; n++) begin
      if (disturb && n == 2) begin
        start = 1'b1;
        dwell = DW'($urandom);
        cont  = ~c;
      end
      if (disturb && n == 3) start = 1'b0;
      exp_busy  = c ? 1'b1 : (n <= p);
      exp_sel   = exp_busy ? ((n - 1) / (d + 1)) % 4 : 0;
      exp_valid = (n > 1) && ((n - 1) % p == 0) && (c || n == p + 1);
      chk($sformatf("busy d=%0d n=%0d", d, n), busy, exp_busy);
      chk($sformatf("select d=%0d n=%0d", d, n), select, exp_sel);
      chk($sformatf("valid d=%0d n=%0d", d, n), sample_valid, exp_valid);
      if (exp_valid) begin
        chk($sformatf("sample d=%0d n=%0d", d, n), sample, scan_val);
        chk($sformatf("changed d=%0d n=%0d", d, n), sample_changed, scan_val != model_prev);
        model_prev = scan_val;
        if (c && pat < 0) begin
          chan_val = 4'($urandom);
          scan_val = chan_val;
        end
      end else begin
        chk($sformatf("sample_hold d=%0d n=%0d", d, n), sample, model_prev);
        chk($sformatf("changed_low d=%0d n=%0d", d, n), sample_changed, 1'b0);
      end
      @(negedge clk);
    end
  endtask

  task automatic abort_and_check(input string tag);
    en = 1'b0;
    @(negedge clk);
    chk({tag, " busy"}, busy, 1'b0);
    chk({tag, " select"}, select, 2'd0);
    chk({tag, " valid"}, sample_valid, 1'b0);
    chk({tag, " sample"}, sample, model_prev);
    en = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #1;
    chk("reset select", select, 2'd0);
    chk("reset busy", busy, 1'b0);
    chk("reset sample", sample, 4'h0);
    chk("reset valid", sample_valid, 1'b0);
    chk("reset changed", sample_changed, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b1;
    @(negedge clk);

    // Single-shot, one cycle per channel, pattern 1010b.
    run_scan(0, 1'b0, 8, 4'b1010, 1'b0);
    // Continuous, dwell 3, all channels high.
    run_scan(3, 1'b1, 3 * 16 + 2, 4'hF, 1'b0);
    abort_and_check("cont_stop");

    // Abort at cycle 6 of a dwell=2 scan.
    run_scan(2, 1'b0, 5, -1, 1'b0);
    // Now at negedge of cycle 6; dropping en here takes effect at its edge.
    abort_and_check("abort_d2");
    for (int i = 0; i < 10; i++) begin
      chk("no_valid_after_abort", sample_valid, 1'b0);
      @(negedge clk);
    end
    run_scan(2, 1'b0, 14, -1, 1'b0);

    // Start re-pulse and dwell/cont change while busy.
    run_scan(1, 1'b0, 10, -1, 1'b1);
    run_scan(3, 1'b0, 18, -1, 1'b0);

    // Random single-shot and continuous scans.
    for (int k = 0; k < 6; k++) begin
      int d;
      d = int'($urandom_range(0, 5));
      run_scan(d, 1'b0, 4 * (d + 1) + 2, -1, 1'b0);
    end
    for (int k = 0; k < 3; k++) begin
      int d;
      d = int'($urandom_range(0, 3));
      run_scan(d, 1'b1, 4 * 4 * (d + 1) + 2, -1, 1'b0);
      abort_and_check("rand_cont_stop");
    end

    // Asynchronous reset between edges mid-scan.
    dwell    = 4'd2;
    cont     = 1'b1;
    chan_val = 4'b0110;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst select", select, 2'd0);
    chk("async_rst busy", busy, 1'b0);
    chk("async_rst sample", sample, 4'h0);
    chk("async_rst valid", sample_valid, 1'b0);
    chk("async_rst changed", sample_changed, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    model_prev = 4'h0;
    @(negedge clk);
    run_scan(1, 1'b0, 10, 4'b0110, 1'b0);

    // Maximum dwell: 16 cycles per channel, valid at cycle 65.
    run_scan(15, 1'b0, 70, -1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
